// File: rtl/dac_spi_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_rx_if
//  Description : 3-wire DAC link (sclk, cs_n, sin) plus the receiver's
//                parallel frame reporting signals, bundled for dac_spi_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_spi_rx_if #(
   parameter int FRAME_BITS = 16
);
   logic                  dac_sclk;
   logic                  dac_cs_n;
   logic                  dac_sin;
   logic [FRAME_BITS-1:0] rx_val;
   logic                  rx_valid;
   logic                  rx_err;
   logic                  rx_busy;

   // Link driver / frame consumer side
   modport master (
      output dac_sclk, dac_cs_n, dac_sin,
      input  rx_val, rx_valid, rx_err, rx_busy
   );

   // Receiver side
   modport slave (
      input  dac_sclk, dac_cs_n, dac_sin,
      output rx_val, rx_valid, rx_err, rx_busy
   );
endinterface
`default_nettype wire

// File: rtl/dac_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_rx
//  Description : Oversampling receiver for the DAC driver's 3-wire link.
//                Rebuilds each cs_n-delimited frame (MSB first) into a
//                parallel word and flags it as good (rx_valid) or bad (rx_err).
//  Options     : define DAC_SPI_RX_STATS_EN to add the frame_cnt / err_cnt
//                saturating statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_rx #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 4096
) (
   input  wire         clk,
   input  wire         rst,
   dac_spi_rx_if.slave bus
`ifdef DAC_SPI_RX_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
`endif
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(FRAME_BITS + 1);
   localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_WAIT_HI = 2'd2
   } state_t;

   // Synchronizers, edge-detect delay flops and registered edge strobes
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sin_sync;
   logic                   r_sclk_dly, r_cs_dly;
   logic                   r_sclk_rise, r_cs_rise, r_cs_fall, r_sin_smp;

   // Frame state
   state_t                 r_state, w_state;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt;
   logic [TO_W-1:0]        r_to_cnt, w_to_cnt;
   logic [FRAME_BITS-1:0]  r_shift, w_shift;
   logic [FRAME_BITS-1:0]  r_val, w_val;
   logic                   r_valid, w_valid;
   logic                   r_err, w_err;

   // Synchronize the link and register the edge strobes; the strobe register
   // puts the frame-end pulse SYNC_STAGES+2 edges after cs_n is first seen high.
   // sin is registered alongside so it stays aligned with its sclk strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_sin_sync  <= '0;
         r_sclk_dly  <= 1'b0;
         r_cs_dly    <= 1'b1;
         r_sclk_rise <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_sin_smp   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.dac_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.dac_cs_n};
         r_sin_sync  <= {r_sin_sync[SYNC_STAGES-2:0],  bus.dac_sin};
         r_sclk_dly  <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_dly    <= r_cs_sync[SYNC_STAGES-1];
         r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_dly;
         r_cs_rise   <= r_cs_sync[SYNC_STAGES-1]   & ~r_cs_dly;
         r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1]  &  r_cs_dly;
         r_sin_smp   <= r_sin_sync[SYNC_STAGES-1];
      end
   end

   // Frame state register and output pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_to_cnt  <= '0;
         r_shift   <= '0;
         r_val     <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_bit_cnt <= w_bit_cnt;
         r_to_cnt  <= w_to_cnt;
         r_shift   <= w_shift;
         r_val     <= w_val;
         r_valid   <= w_valid;
         r_err     <= w_err;
      end
   end

   // Next-state logic; a cs_n rise takes priority over both a coincident
   // sclk rise (that bit is dropped) and the timeout.
   always_comb begin
      w_state   = r_state;
      w_bit_cnt = r_bit_cnt;
      w_to_cnt  = r_to_cnt;
      w_shift   = r_shift;
      w_val     = r_val;
      w_valid   = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_cs_fall) begin
               w_state   = ST_SHIFT;
               w_bit_cnt = '0;
               w_to_cnt  = '0;
            end
         end
         ST_SHIFT: begin
            if (r_cs_rise) begin
               if (r_bit_cnt == C_CNT_FULL) begin
                  w_val   = r_shift;
                  w_valid = 1'b1;
               end else begin
                  w_err   = 1'b1;
               end
               w_state = ST_IDLE;
            end else if (r_to_cnt == C_TO_LAST) begin
               w_err   = 1'b1;
               w_state = ST_WAIT_HI;
            end else begin
               w_to_cnt = r_to_cnt + TO_W'(1);
               if (r_sclk_rise) begin
                  w_shift = {r_shift[FRAME_BITS-2:0], r_sin_smp};
                  if (r_bit_cnt != C_CNT_MAX) begin
                     w_bit_cnt = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
         end
         ST_WAIT_HI: begin
            if (r_cs_rise) begin
               w_state = ST_IDLE;
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign bus.rx_val   = r_val;
   assign bus.rx_valid = r_valid;
   assign bus.rx_err   = r_err;
   assign bus.rx_busy  = (r_state != ST_IDLE);

`ifdef DAC_SPI_RX_STATS_EN
   logic [15:0] r_frame_cnt, r_err_cnt;

   // Saturating good-frame / error counters, stepped with their pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_valid && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_rx
//  Description : Self-checking bench for dac_spi_rx: table of fixed frames,
//                hand-written corner sequences, and random frames checked
//                against a bit-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_rx;

   localparam int FB = 16;
   localparam int SS = 2;
   localparam int TO = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;

   dac_spi_rx_if #(.FRAME_BITS(FB)) bus ();

`ifdef DAC_SPI_RX_STATS_EN
   logic [15:0] frame_cnt, err_cnt;
`endif

   dac_spi_rx #(
      .FRAME_BITS  (FB),
      .SYNC_STAGES (SS),
      .TIMEOUT     (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DAC_SPI_RX_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   typedef struct {
      int          cyc;
      bit          is_err;
      logic [15:0] val;
   } ev_t;

   typedef struct {
      logic [31:0] data;
      int          nbits;
      bit          exp_err;
      logic [15:0] exp_val;
   } vec_t;

   ev_t ev_q[$];
   int  viol   = 0;
   bit  prev_v = 1'b0;
   bit  prev_e = 1'b0;
   int  n_pass  = 0;
   int  n_total = 0;

   // cycle stamp of the most recent clk edge
   always @(posedge clk) cyc <= cyc + 1;

   // record every result pulse and count protocol violations on the pulses
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_valid || bus.rx_err)
            ev_q.push_back('{cyc, bus.rx_err, bus.rx_val});
         if (bus.rx_valid && bus.rx_err) viol <= viol + 1;
         if (bus.rx_valid && prev_v)     viol <= viol + 1;
         if (bus.rx_err && prev_e)       viol <= viol + 1;
      end
      prev_v <= bus.rx_valid;
      prev_e <= bus.rx_err;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive_bits(input logic [31:0] data, input int nbits, input int hi, input int lo);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.dac_sin  = data[i];
         bus.dac_sclk = 1'b0;
         step(lo);
         bus.dac_sclk = 1'b1;
         step(hi);
      end
      bus.dac_sclk = 1'b0;
      step(lo);
   endtask

   task automatic frame(input logic [31:0] data, input int nbits, input int hi, input int lo,
                        output int t_rise);
      bus.dac_cs_n = 1'b0;
      step(4);
      drive_bits(data, nbits, hi, lo);
      bus.dac_cs_n = 1'b1;
      t_rise = cyc;
      step(SS + 4);
   endtask

   // exactly one pulse of the right kind, SS+2 edges after cs_n rise
   task automatic check_outcome(input string name, input int t_rise, input bit exp_err,
                                input logic [15:0] exp_val);
      check({name, "_npulse"}, ev_q.size(), 1);
      if (ev_q.size() >= 1) begin
         check({name, "_kind"}, ev_q[0].is_err, exp_err);
         check({name, "_cycle"}, ev_q[0].cyc, t_rise + SS + 2);
         check({name, "_val"}, ev_q[0].val, exp_val);
      end
      check({name, "_rx_val"}, bus.rx_val, exp_val);
      ev_q.delete();
   endtask

   initial begin
      vec_t        vecs[6];
      int          t;
      int          any;
      logic [15:0] m_val;

      vecs[0] = '{32'h0000_aaaa, 16, 1'b0, 16'haaaa};
      vecs[1] = '{32'h0000_5555, 16, 1'b0, 16'h5555};
      vecs[2] = '{32'h0000_a5a5, 16, 1'b0, 16'ha5a5};
      vecs[3] = '{32'h0000_5a5a, 16, 1'b0, 16'h5a5a};
      vecs[4] = '{32'h0000_1234, 15, 1'b1, 16'h5a5a};
      vecs[5] = '{32'h0001_ffff, 17, 1'b1, 16'h5a5a};

      bus.dac_sclk = 1'b0;
      bus.dac_cs_n = 1'b1;
      bus.dac_sin  = 1'b0;

      // reset and idle link
      step(3);
      check("rst_rx_val", bus.rx_val, 16'h0);
      check("rst_busy", bus.rx_busy, 1'b0);
      check("rst_valid", bus.rx_valid, 1'b0);
      rst = 1'b0;
      any = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (bus.rx_valid || bus.rx_err || bus.rx_busy || (bus.rx_val != 16'h0)) any++;
      end
      check("idle_activity", any, 0);
      check("idle_events", ev_q.size(), 0);

      // fixed frame table
      for (int i = 0; i < 6; i++) begin
         frame(vecs[i].data, vecs[i].nbits, 4, 4, t);
         check_outcome($sformatf("vec%0d", i), t, vecs[i].exp_err, vecs[i].exp_val);
      end

      // cs_n held low far past the timeout
      bus.dac_cs_n = 1'b0;
      t = cyc;
      for (int i = 0; i < 625; i++) begin
         bus.dac_sclk = 1'b0;
         bus.dac_sin  = 1'($urandom_range(0, 1));
         step(4);
         bus.dac_sclk = 1'b1;
         step(4);
      end
      check("to_npulse", ev_q.size(), 1);
      if (ev_q.size() >= 1) begin
         check("to_kind", ev_q[0].is_err, 1'b1);
         check("to_cycle", ev_q[0].cyc, t + SS + 2 + TO);
      end
      check("to_busy_held", bus.rx_busy, 1'b1);
      bus.dac_sclk = 1'b0;
      step(4);
      bus.dac_cs_n = 1'b1;
      step(SS + 8);
      check("to_no_second", ev_q.size(), 1);
      check("to_busy_clear", bus.rx_busy, 1'b0);
      check("to_rx_val", bus.rx_val, 16'h5a5a);
      ev_q.delete();

      // 17th sclk rise coincident with cs_n rise is discarded
      bus.dac_cs_n = 1'b0;
      step(4);
      drive_bits(32'h1234, 16, 4, 4);
      bus.dac_sin  = 1'b1;
      bus.dac_sclk = 1'b1;
      bus.dac_cs_n = 1'b1;
      t = cyc;
      step(SS + 4);
      bus.dac_sclk = 1'b0;
      step(4);
      check_outcome("coinc", t, 1'b0, 16'h1234);

      // random frames against a bit-queue model
      m_val = 16'h1234;
      for (int f = 0; f < 24; f++) begin
         bit          q[$];
         logic [31:0] data;
         logic [15:0] pk;
         int          nb;
         int          hi;
         int          lo;
         bit          e_err;
         nb = ($urandom_range(0, 3) < 2) ? 16 : int'($urandom_range(13, 19));
         data = $urandom;
         hi = $urandom_range(3, 6);
         lo = $urandom_range(3, 6);
         q.delete();
         for (int b = nb - 1; b >= 0; b--) q.push_back(data[b]);
         if (q.size() == FB) begin
            pk = '0;
            foreach (q[k]) pk = {pk[14:0], q[k]};
            m_val = pk;
            e_err = 1'b0;
         end else begin
            e_err = 1'b1;
         end
         frame(data, nb, hi, lo, t);
         check_outcome($sformatf("rnd%0d_n%0d", f, nb), t, e_err, m_val);
         step($urandom_range(0, 4));
      end

      // reset in the middle of a frame, cs_n still low on release
      bus.dac_cs_n = 1'b0;
      step(4);
      drive_bits(32'hff, 8, 4, 4);
      rst = 1'b1;
      step(2);
      check("midrst_rx_val", bus.rx_val, 16'h0);
      check("midrst_busy", bus.rx_busy, 1'b0);
      rst = 1'b0;
      ev_q.delete();
      step(4);
      drive_bits(32'hff, 8, 4, 4);
      bus.dac_cs_n = 1'b1;
      t = cyc;
      step(SS + 4);
      check_outcome("post_rst_short", t, 1'b1, 16'h0000);
      frame(32'h0f0f, 16, 4, 4, t);
      check_outcome("post_rst_good", t, 1'b0, 16'h0f0f);
`ifdef DAC_SPI_RX_STATS_EN
      check("stat_frame_cnt", frame_cnt, 16'd1);
      check("stat_err_cnt", err_cnt, 16'd1);
`endif

      step(2);
      check("pulse_rules", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
